// File: rtl/k16_fb_arbiter_pkg.sv
// Shared types and default widths for the k16 frame buffer arbiter.
// The fill-state enum is only consumed when K16_FB_FILL_EN is defined.
package k16_fb_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W   = 11;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_FB_WORDS = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/k16_fb_fill.sv
// Frame buffer fill engine: writes a constant word over a wrapping address range,
// one word per cycle in which no higher-priority requester owns the bus.
module k16_fb_fill
    import k16_fb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned FB_WORDS = DEF_FB_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] value,
    input  logic              slot,
    output logic              req_c,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    fill_state_e      state;
    logic [LEN_W-1:0] offset;
    logic [LEN_W-1:0] last_q;

    assign req_c = (state == RUN);

    // A zero length means the whole buffer, so the last offset is FB_WORDS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            offset <= '0;
            last_q <= '0;
            addr   <= '0;
            wdata  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr   <= base;
                        wdata  <= value;
                        last_q <= (len == '0) ? LEN_W'(FB_WORDS - 1) : len - LEN_W'(1);
                        offset <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (slot) begin
                        addr   <= (addr == ADDR_W'(FB_WORDS - 1)) ? '0 : addr + ADDR_W'(1);
                        offset <= offset + LEN_W'(1);
                        if (offset == last_q) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done   <= 1'b0;
                    busy   <= 1'b0;
                    offset <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/k16_fb_arbiter.sv
// Single-port frame buffer arbiter, fixed priority video > CPU > fill.
// Define K16_FB_FILL_EN to build in the fill engine (k16_fb_fill).
module k16_fb_arbiter
    import k16_fb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned FB_WORDS = DEF_FB_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_grant,
    output logic              vid_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_hold,
    output logic              cpu_rvalid,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_we,
    output logic [DATA_W-1:0] fb_wdata,
    input  logic [DATA_W-1:0] fb_rdata
);

    logic              vid_win_c;
    logic              cpu_win_c;
    logic              fill_win_c;
    logic              fill_slot_c;
    logic              fill_req_c;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_wdata;

    // Grants are gated by reset so the bus is quiet while reset is held.
    assign vid_win_c   = reset & vid_req;
    assign cpu_win_c   = reset & cpu_req & ~vid_req;
    assign fill_slot_c = ~vid_req & ~cpu_req;
    assign fill_win_c  = reset & fill_req_c & fill_slot_c;
    assign vid_grant   = vid_win_c;
    assign cpu_hold    = reset & cpu_req & vid_req;

    always_comb begin
        fb_we    = 1'b0;
        fb_addr  = '0;
        fb_wdata = '0;
        if (vid_win_c) begin
            fb_addr = vid_addr;
        end else if (cpu_win_c) begin
            fb_we    = cpu_we;
            fb_addr  = cpu_addr;
            fb_wdata = cpu_wdata;
        end else if (fill_win_c) begin
            fb_we    = 1'b1;
            fb_addr  = fill_addr;
            fb_wdata = fill_wdata;
        end
    end

    // Read data returns one cycle after issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vid_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
        end else begin
            vid_rvalid <= vid_win_c;
            cpu_rvalid <= cpu_win_c & ~cpu_we;
        end
    end

`ifdef K16_FB_FILL_EN
    k16_fb_fill #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .FB_WORDS (FB_WORDS)
    ) u_fill (
        .clk   (clk),
        .rst_n (reset),
        .start (fill_start),
        .base  (fill_base),
        .len   (fill_len),
        .value (fill_value),
        .slot  (fill_slot_c),
        .req_c (fill_req_c),
        .addr  (fill_addr),
        .wdata (fill_wdata),
        .busy  (fill_busy),
        .done  (fill_done)
    );
`else
    logic fill_unused_c;

    assign fill_req_c    = 1'b0;
    assign fill_addr     = '0;
    assign fill_wdata    = '0;
    assign fill_busy     = 1'b0;
    assign fill_done     = 1'b0;
    assign fill_unused_c = ^{fill_start, fill_base, fill_len, fill_value};
`endif

endmodule

// File: doc/k16_fb_arbiter.md
K16_FB_ARBITER -- requirements
Module: k16_fb_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 11, frame buffer word address width; DATA_W, default 16, word width; FB_WORDS, default 2048, frame buffer depth.
REQ-002 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- vid_req  in  1  video read request
- vid_addr  in  ADDR_W  video read address
- vid_grant  out  1  video read issued this cycle
- vid_rvalid  out  1  fb_rdata holds video data
- cpu_req  in  1  CPU frame buffer access
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_hold  out  1  stall CPU
- cpu_rvalid  out  1  fb_rdata holds CPU read data
- fill_start  in  1  start-fill pulse
- fill_base  in  ADDR_W  first fill address
- fill_len  in  ADDR_W+1  word count
- fill_value  in  DATA_W  fill word
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle completion pulse
- fb_addr  out  ADDR_W  frame buffer address
- fb_we  out  1  frame buffer write enable
- fb_wdata  out  DATA_W  frame buffer write data
- fb_rdata  in  DATA_W  frame buffer read data, 1-cycle latency

Function
REQ-003 Exactly one frame buffer access SHALL be issued per cycle; fixed priority video > CPU > fill.
REQ-004 fb_addr/fb_we/fb_wdata SHALL be combinational from the winning requester; no winner -> fb_we=0, fb_addr=0.
REQ-005 vid_grant SHALL equal vid_req; vid_rvalid SHALL be vid_grant delayed one cycle.
REQ-006 cpu_hold SHALL be 1 when cpu_req=1 and vid_req=1, else 0; CPU access is issued in the first cycle without video.
REQ-007 cpu_rvalid SHALL be 1 the cycle after a granted CPU read (cpu_we=0); never for writes.
REQ-008 Fill FSM states SHALL be IDLE, RUN, DONE.
REQ-009 IDLE: fill_start=1 -> latch base, len, value; go to RUN. fill_len=0 SHALL mean FB_WORDS words.
REQ-010 RUN: one word written each cycle neither video nor CPU wins; address = (base + offset) mod FB_WORDS; after the last word -> DONE.
REQ-011 DONE: fill_done=1 for exactly one cycle; -> IDLE.
REQ-012 fill_busy SHALL be 1 in RUN and DONE.
REQ-013 fill_start in RUN or DONE SHALL be ignored.
REQ-014 fill_start with a competing CPU/video request in the same cycle SHALL be latched; the first fill write comes no earlier than the next cycle.
REQ-015 An access lost to a higher-priority requester SHALL NOT advance the fill offset.

Reset
REQ-016 reset=0 SHALL asynchronously force: FSM IDLE, offset 0, vid_rvalid=0, cpu_rvalid=0, fill_busy=0, fill_done=0.
REQ-017 During reset, fb_we, cpu_hold and vid_grant SHALL be 0.
REQ-018 Reset during RUN SHALL abort the fill with no fill_done pulse; words already written remain.

Configuration
REQ-019 Macro K16_FB_FILL_EN defined: fill engine present as specified.
REQ-020 Macro undefined: no fill logic; fill_busy=0, fill_done=0; fill_* inputs ignored; arbitration is video > CPU only.

Structure
REQ-021 The shared package SHALL hold the fill-state enum (IDLE/RUN/DONE) and default width constants (ADDR_W=11, DATA_W=16, FB_WORDS=2048).
REQ-022 The fill engine SHALL be a sub-module, k16_fb_fill, instantiated only under K16_FB_FILL_EN.

Verification
REQ-023 Idle bus, CPU write 0x1234 @0x005 -> fb_we=1, fb_addr=0x005, fb_wdata=0x1234 same cycle, cpu_hold=0.
REQ-024 vid_req and cpu_req read @0x010 together for 3 cycles, then vid_req drops -> cpu_hold=1 for 3 cycles; CPU read issued cycle 4; cpu_rvalid cycle 5.
REQ-025 Fill base=0x7FE, len=4, value=0xAAAA, no contention -> writes 0x7FE, 0x7FF, 0x000, 0x001 on consecutive cycles; fill_done one cycle later.
REQ-026 Fill len=8, CPU write injected at fill word 3 -> that cycle carries CPU write; all 8 fill words still written in order; done delayed one cycle.
REQ-027 Fill len=0 -> 2048 writes; fill_done exactly once; second fill_start mid-run ignored.
REQ-028 reset=0 asserted mid-fill (async, between edges) -> outputs cleared immediately, no fill_done; new fill after release runs normally.
